// File: rtl/axi_ifm_rd_if.sv
// AXI4 read-address and read-data channels between the IFM loader (master)
// and the memory interconnect (slave). Write channels are not carried here.
interface axi_ifm_rd_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ID_W   = 1
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_ifm_loader.sv
// Read DMA feeding the systolic array's IFM buffer: issues AXI4 INCR read
// bursts (one outstanding), packs beat pairs into wide IFM words and writes
// them to sequential IFM RAM addresses.
module axi_ifm_loader #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_BURST_LEN  = 256,
    parameter int INOUT_WIDTH        = 256,
    parameter int IFM_RAM_SIZE       = 524172,
    localparam int AW                = $clog2(IFM_RAM_SIZE)
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          start_read,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [AW-1:0]                 num_words,
    axi_ifm_rd_if.master                  m_axi,
    output logic                          ifm_write_en,
    output logic [AW-1:0]                 ifm_addr_write,
    output logic [INOUT_WIDTH-1:0]        ifm_data_write,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);
    localparam int BW         = AW + 1;  // beat counter width (2 beats per word)
    localparam int BEAT_SHIFT = $clog2(C_M_AXI_DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ARLEN for the next burst: whole remainder, capped at the max burst
    function automatic logic [7:0] arlen_f(input logic [BW-1:0] beats);
        if (beats >= BW'(C_M_AXI_BURST_LEN)) begin
            arlen_f = 8'(C_M_AXI_BURST_LEN - 1);
        end else begin
            arlen_f = beats[7:0] - 8'd1;
        end
    endfunction

    state_t                        state_r, state_next_s;
    logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr_r;
    logic [BW-1:0]                 remaining_r;
    logic [8:0]                    burst_left_r;
    logic [7:0]                    arlen_r;
    logic                          arvalid_r, rready_r, done_r, busy_r, error_r;
    logic                          arvalid_d_s, rready_d_s, done_d_s, busy_d_s;
    logic                          we_r, odd_r;
    logic [AW-1:0]                 wr_ptr_r, ifm_addr_r;
    logic [C_M_AXI_DATA_WIDTH-1:0] lo_r;
    logic [INOUT_WIDTH-1:0]        ifm_data_r;
    logic                          start_ok_s, ar_hs_s, beat_s, last_beat_s;

    assign start_ok_s  = (state_r == ST_IDLE) && start_read;
    assign ar_hs_s     = arvalid_r && m_axi.arready;
    assign beat_s      = m_axi.rvalid && rready_r;
    assign last_beat_s = beat_s && (burst_left_r == 9'd1);

    // State register
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_read) begin
                    if (num_words == AW'(0)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ADDR;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (ar_hs_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (last_beat_s) begin
                    if (remaining_r != BW'(1)) begin
                        state_next_s = ST_ADDR;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the next state so they can be registered
    always_comb begin
        arvalid_d_s = 1'b0;
        rready_d_s  = 1'b0;
        done_d_s    = 1'b0;
        busy_d_s    = 1'b0;
        case (state_next_s)
            ST_ADDR: begin
                arvalid_d_s = 1'b1;
                busy_d_s    = 1'b1;
            end
            ST_DATA: begin
                rready_d_s = 1'b1;
                busy_d_s   = 1'b1;
            end
            ST_DONE: done_d_s = 1'b1;
            default: busy_d_s = 1'b0;
        endcase
    end

    // Datapath: addresses, beat counters, beat packing, error tracking
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            error_r      <= 1'b0;
            cur_addr_r   <= '0;
            remaining_r  <= '0;
            burst_left_r <= 9'd0;
            arlen_r      <= 8'd0;
            we_r         <= 1'b0;
            odd_r        <= 1'b0;
            wr_ptr_r     <= '0;
            ifm_addr_r   <= '0;
            lo_r         <= '0;
            ifm_data_r   <= '0;
        end else begin
            arvalid_r <= arvalid_d_s;
            rready_r  <= rready_d_s;
            done_r    <= done_d_s;
            busy_r    <= busy_d_s;
            we_r      <= beat_s && odd_r;
            if (start_ok_s) begin
                cur_addr_r  <= base_addr;
                remaining_r <= {num_words, 1'b0};
                arlen_r     <= arlen_f({num_words, 1'b0});
                error_r     <= 1'b0;
                wr_ptr_r    <= '0;
                odd_r       <= 1'b0;
            end
            if (ar_hs_s) begin
                burst_left_r <= {1'b0, arlen_r} + 9'd1;
            end
            if (beat_s) begin
                remaining_r  <= remaining_r - BW'(1);
                burst_left_r <= burst_left_r - 9'd1;
                odd_r        <= ~odd_r;
                // Beat counting follows ARLEN; RLAST is only cross-checked
                if ((m_axi.rresp != 2'b00) || (m_axi.rlast != (burst_left_r == 9'd1))) begin
                    error_r <= 1'b1;
                end
                if (!odd_r) begin
                    lo_r <= m_axi.rdata;
                end else begin
                    ifm_data_r <= {m_axi.rdata, lo_r};
                    ifm_addr_r <= wr_ptr_r;
                    wr_ptr_r   <= wr_ptr_r + AW'(1);
                end
            end
            if (last_beat_s) begin
                cur_addr_r <= cur_addr_r +
                    (C_M_AXI_ADDR_WIDTH'({1'b0, arlen_r} + 9'd1) << BEAT_SHIFT);
                arlen_r    <= arlen_f(remaining_r - BW'(1));
            end
        end
    end

    assign m_axi.arid    = {C_M_AXI_ID_WIDTH{1'b0}};
    assign m_axi.araddr  = cur_addr_r;
    assign m_axi.arlen   = arlen_r;
    assign m_axi.arsize  = 3'b100;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arqos   = 4'b0000;
    assign m_axi.arvalid = arvalid_r;
    assign m_axi.rready  = rready_r;

    assign ifm_write_en   = we_r;
    assign ifm_addr_write = ifm_addr_r;
    assign ifm_data_write = ifm_data_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;
endmodule

// File: tb/tb_axi_ifm_loader.sv
// Bench for axi_ifm_loader: table of load requests driven through a bench
// AXI slave; expected AR requests and IFM writes go into scoreboard queues.
module tb_axi_ifm_loader;
    localparam int AW = 19;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_read;
    logic [31:0]     base_addr;
    logic [AW-1:0]   num_words;
    logic            ifm_write_en;
    logic [AW-1:0]   ifm_addr_write;
    logic [255:0]    ifm_data_write;
    logic            busy, done, error;

    axi_ifm_rd_if #(.ADDR_W(32), .DATA_W(128), .ID_W(1)) axi ();

    axi_ifm_loader u_dut (
        .M_AXI_ACLK     (clk),
        .M_AXI_ARESETN  (rst_n),
        .start_read     (start_read),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .m_axi          (axi),
        .ifm_write_en   (ifm_write_en),
        .ifm_addr_write (ifm_addr_write),
        .ifm_data_write (ifm_data_write),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] base;
        bit          throttle;
        int          resp_err;
        int          last_err;
        int          rst_beat;
        bit          exp_err;
    } tc_t;

    typedef struct { logic [AW-1:0] a; logic [255:0] d; } wr_t;
    typedef struct { logic [31:0] a; logic [7:0] l; } ar_t;

    wr_t wq[$];
    ar_t aq[$];
    int  n_pass = 0;
    int  n_chk  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] bd(input int c, input int j);
        logic [31:0] jj;
        jj = 32'(j);
        return {jj, ~jj, (32'(c) << 8) ^ 32'h5a5a_0000, jj};
    endfunction

    task automatic run_case(input tc_t t, input int c);
        int          rem, j, burst_left, wait_cnt, cyc;
        bit          got_done, in_ar;
        logic [31:0] addr, ar_a;
        logic [7:0]  ar_l, l;
        logic [127:0] prev;
        ar_t e;
        wr_t w;
        aq.delete();
        wq.delete();
        rem = 2 * t.n;
        addr = t.base;
        while (rem > 0) begin
            l = (rem >= 256) ? 8'd255 : 8'(rem - 1);
            aq.push_back('{addr, l});
            addr = addr + ((32'(l) + 32'd1) * 32'd16);
            rem = rem - (int'(l) + 1);
        end
        j = 0; burst_left = 0; wait_cnt = 0; got_done = 0; in_ar = 0; prev = '0;
        ar_a = '0; ar_l = '0;
        @(negedge clk);
        start_read = 1'b1;
        base_addr  = t.base;
        num_words  = AW'(t.n);
        axi.arready = !t.throttle;
        axi.rvalid  = 1'b0;
        @(negedge clk);
        start_read = 1'b0;
        chk("start_arvalid", 256'(axi.arvalid), 256'(t.n != 0));
        chk("start_error_clear", 256'(error), 256'(0));
        for (cyc = 0; cyc < 4000 && !got_done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (ifm_write_en) begin
                if (wq.size() == 0) chk("spurious_write", 256'(1), 256'(0));
                else begin
                    w = wq.pop_front();
                    chk("wr_addr", 256'(ifm_addr_write), 256'(w.a));
                    chk("wr_data", ifm_data_write, w.d);
                end
            end
            if (done) begin
                got_done = 1;
                chk("done_wq_empty", 256'(wq.size()), 256'(0));
                chk("done_aq_empty", 256'(aq.size()), 256'(0));
                chk("done_busy_low", 256'(busy), 256'(0));
                chk("error_at_done", 256'(error), 256'(t.exp_err));
                chk("done_with_write", 256'(ifm_write_en), 256'(t.n != 0));
                if (t.n == 0) chk("zero_done_latency", 256'(cyc), 256'(0));
            end else if (cyc == 0 && t.n != 0) begin
                chk("busy_after_start", 256'(busy), 256'(1));
            end
            if (t.rst_beat >= 0 && j >= t.rst_beat) begin
                rst_n = 1'b0;
                #1;
                chk("rst_arvalid", 256'(axi.arvalid), 256'(0));
                chk("rst_rready", 256'(axi.rready), 256'(0));
                chk("rst_araddr", 256'(axi.araddr), 256'(0));
                chk("rst_we", 256'(ifm_write_en), 256'(0));
                chk("rst_addr_data", {ifm_data_write[236:0], ifm_addr_write}, 256'(0));
                chk("rst_flags", 256'({busy, done, error}), 256'(0));
                axi.rvalid = 1'b0;
                axi.rlast  = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            // R channel first, so a burst only starts after its AR handshake
            if (burst_left > 0) begin
                axi.rvalid = t.throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
                axi.rdata  = bd(c, j);
                axi.rresp  = (j == t.resp_err) ? 2'b10 : 2'b00;
                axi.rlast  = (burst_left == 1) ^ (j == t.last_err);
                if (axi.rvalid && axi.rready) begin
                    if (j % 2 == 0) prev = axi.rdata;
                    else wq.push_back('{AW'(j / 2), {axi.rdata, prev}});
                    j++;
                    burst_left--;
                end
            end else begin
                axi.rvalid = 1'b0;
            end
            if (axi.arvalid) begin
                if (!in_ar) begin
                    in_ar = 1;
                    wait_cnt = 0;
                    if (aq.size() == 0) chk("unexpected_ar", 256'(1), 256'(0));
                    else begin
                        e = aq.pop_front();
                        chk("araddr", 256'(axi.araddr), 256'(e.a));
                        chk("arlen", 256'(axi.arlen), 256'(e.l));
                    end
                    ar_a = axi.araddr;
                    ar_l = axi.arlen;
                end else begin
                    chk("araddr_stable", 256'(axi.araddr), 256'(ar_a));
                    chk("arlen_stable", 256'(axi.arlen), 256'(ar_l));
                end
                axi.arready = t.throttle ? (wait_cnt >= 5) : 1'b1;
                wait_cnt++;
                if (axi.arready) begin
                    in_ar = 0;
                    burst_left = int'(ar_l) + 1;
                end
            end else begin
                axi.arready = !t.throttle;
            end
        end
        if (!got_done) chk("timeout_done", 256'(0), 256'(1));
        @(negedge clk);
        chk("done_one_cycle", 256'(done), 256'(0));
        chk("idle_not_busy", 256'(busy), 256'(0));
    endtask

    tc_t tc[9];

    initial begin
        tc[0] = '{4,   32'h4000_0000, 1'b0, -1, -1, -1, 1'b0};
        tc[1] = '{200, 32'h4000_0000, 1'b0, -1, -1, -1, 1'b0};
        tc[2] = '{4,   32'h4000_0000, 1'b1, -1, -1, -1, 1'b0};
        tc[3] = '{4,   32'h4000_0000, 1'b0,  3, -1, -1, 1'b1};
        tc[4] = '{4,   32'h4000_0000, 1'b0, -1,  5, -1, 1'b1};
        tc[5] = '{0,   32'h4000_0000, 1'b0, -1, -1, -1, 1'b0};
        tc[6] = '{8,   32'h4000_0000, 1'b0, -1, -1, 10, 1'b0};
        tc[7] = '{4,   32'h4000_0000, 1'b0, -1, -1, -1, 1'b0};
        tc[8] = '{130, 32'h8000_0000, 1'b1, -1, -1, -1, 1'b0};

        start_read  = 1'b0;
        base_addr   = '0;
        num_words   = '0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 256'({axi.arvalid, axi.rready, ifm_write_en, busy, done, error}), 256'(0));
        chk("reset_ar_const", 256'({axi.arid, axi.arsize, axi.arburst, axi.arlock,
                                   axi.arcache, axi.arprot, axi.arqos}),
            256'({1'b0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000}));
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_case(tc[i], i);

        // Zero-length request by hand: done one cycle after start, nothing else
        @(negedge clk);
        start_read = 1'b1;
        num_words  = '0;
        @(negedge clk);
        start_read = 1'b0;
        chk("hand_zero_done", 256'(done), 256'(1));
        chk("hand_zero_no_ar", 256'({axi.arvalid, ifm_write_en, busy}), 256'(0));
        @(negedge clk);
        chk("hand_zero_done_drop", 256'({done, axi.arvalid}), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axi_ifm_loader.md
# axi_ifm_loader

Read-side DMA stage that sits directly upstream of the systolic array's IFM buffer. On `start_read` it issues AXI4 INCR read bursts on the M00 read channels and packs pairs of 128-bit R beats into 256-bit IFM words. It writes those words to sequential IFM RAM addresses, filling the input feature map before CNN compute begins. One outstanding burst at a time; write channels are not driven by this block.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 32, AXI byte address width.
- `C_M_AXI_DATA_WIDTH`, 128, R beat width.
- `C_M_AXI_ID_WIDTH`, 1, ARID width.
- `C_M_AXI_BURST_LEN`, 256, maximum beats per burst.
- `INOUT_WIDTH`, 256, IFM word width; must equal 2×`C_M_AXI_DATA_WIDTH`.
- `IFM_RAM_SIZE`, 524172, IFM depth in words; `AW = $clog2(IFM_RAM_SIZE)` (19).

Ports:
- `M_AXI_ACLK` in 1: single clock.
- `M_AXI_ARESETN` in 1: asynchronous active-low reset.
- `start_read` in 1: one-cycle request; sampled only in IDLE.
- `base_addr` in C_M_AXI_ADDR_WIDTH: source byte address; must be 4 KB aligned. Sampled with `start_read`.
- `num_words` in AW: number of 256-bit words to load. Sampled with `start_read`.
- `M_AXI_ARID` out ID: constant 0.
- `M_AXI_ARADDR` out ADDR: burst start address.
- `M_AXI_ARLEN` out 8: beats−1.
- `M_AXI_ARSIZE` out 3: constant 3'b100.
- `M_AXI_ARBURST` out 2: constant 2'b01.
- `M_AXI_ARLOCK` / `ARCACHE` / `ARPROT` / `ARQOS` out 1/4/3/4: constants 0 / 4'b0011 / 0 / 0.
- `M_AXI_ARVALID` out 1; `M_AXI_ARREADY` in 1.
- `M_AXI_RDATA` in 128; `M_AXI_RRESP` in 2; `M_AXI_RLAST` in 1; `M_AXI_RVALID` in 1; `M_AXI_RREADY` out 1.
- `ifm_write_en` out 1: IFM RAM write strobe.
- `ifm_addr_write` out AW: IFM word address.
- `ifm_data_write` out 256: packed IFM word.
- `busy` out 1: high from accepted start until the cycle `done` is high (exclusive).
- `done` out 1: one-cycle completion pulse.
- `error` out 1: sticky; cleared on the next accepted `start_read`.

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - On `start_read`, latch `base_addr` and `total_beats = 2*num_words`, clear `error` and the write address.
  - If `num_words==0`, go to DONE; otherwise go to ADDR.
  - `start_read` in any other state is ignored.
- ADDR:
  - Drive `ARVALID=1`, `ARADDR=cur_addr`, `ARLEN=min(remaining_beats, BURST_LEN)-1`, all held stable until `ARREADY`.
  - On the AR handshake, go to DATA.
- DATA:
  - `RREADY=1`. Each `RVALID&&RREADY` beat decrements the burst and total beat counters.
  - Even beat (0, 2, …) is latched into the low half [127:0]; odd beat fills [255:128] and triggers a write.
  - On the final beat of the burst: add `(ARLEN+1)*16` to `cur_addr`, then go to ADDR if `remaining_beats>0`, else DONE.
- DONE: `done=1` for one cycle, then IDLE.
- Error conditions, each setting `error`:
  - `RRESP!=2'b00` on any beat.
  - `RLAST` high on a non-final beat of a burst.
  - `RLAST` low on the final beat of a burst.
- On error, data is still written and beat counting follows ARLEN, not RLAST.
- A full 256-beat burst spans exactly 4 KB, so with an aligned base no burst crosses a 4 KB boundary. Alignment is not checked.
- `ifm_addr_write` increments after each write. It wraps modulo 2^AW; the caller keeps `num_words ≤ IFM_RAM_SIZE`.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, constant AR fields at their fixed values.
- Reset mid-operation forces IDLE immediately; the in-flight burst is abandoned. The interconnect must be reset with it.
- Start latency: `start_read` at cycle t gives `ARVALID=1` at t+1.
- `ARVALID` drops the cycle after the AR handshake. The next burst's `ARVALID` rises the cycle after the previous burst's last beat.
- Write latency: an odd-beat handshake at cycle t gives `ifm_write_en=1` with data and address at t+1 (registered), for exactly one cycle.
- Completion: the final write and the `done` pulse occur in the same cycle; `busy` is low in that cycle.
- `num_words==0`: `done` at t+1, no AR issued.
- `RREADY` is high throughout DATA; the block never back-pressures. Throughput is one beat per cycle.

## Test plan
- **Single short burst:** `num_words=4`, `base=0x40000000`, ARREADY and RVALID held at 1, RDATA=beat index → one AR with ARLEN=7 at 0x40000000. Four writes at addresses 0..3, with word k = {beat 2k+1, beat 2k}. `done` coincides with the write to address 3.
- **Burst split:** `num_words=200` (400 beats) → AR ARLEN=255 at 0x40000000, then ARLEN=143 at 0x40001000. 200 writes at addresses 0..199.
- **Throttled handshakes:** the single-short-burst case with random RVALID gaps and ARREADY delayed 5 cycles → identical write contents and order. ARADDR/ARLEN stay stable while `ARVALID` waits.
- **Response error:** RRESP=2'b10 on beat 3, and separately RLAST early on beat 5 of 8 → `error=1` through `done`; all writes still occur. `error` clears on the next `start_read`.
- **Zero length:** `num_words=0` → `done` pulse at t+1, `ARVALID` never asserted, no writes.
- **Reset mid-burst:** assert `M_AXI_ARESETN=0` after beat 10 → all outputs 0 at once. A fresh `start_read` after release (with the slave reset) completes normally.
